// File: rtl/poly_note_if.sv
// Key/tone bundle between the keyboard/playback logic (master) and the note scheduler (slave).
// Signal widths follow NUM_KEYS the same way the scheduler derives them.
interface poly_note_if #(
  parameter int NUM_KEYS = 8
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W = $clog2(NUM_KEYS + 1);

  logic [1:0]          shift;
  logic [NUM_KEYS-1:0] keys;
  logic [IDX_W-1:0]    note_idx;
  logic                note_valid;
  logic [CNT_W-1:0]    active_count;
  logic                pwm;
  logic                sd;

  modport master (
    output shift, keys,
    input  note_idx, note_valid, active_count, pwm, sd
  );

  modport slave (
    input  shift, keys,
    output note_idx, note_valid, active_count, pwm, sd
  );
endinterface

// File: rtl/poly_note_scheduler.sv
// Round-robin polyphonic key scheduler driving one square-wave tone for the buzzer.
// Define POLY_SCHED_GAP_EN to insert a silent gap of GAP_CYCLES between slices.
module poly_note_scheduler #(
  parameter int NUM_KEYS     = 8,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SLICE_CYCLES = 2_000_000,
  parameter int GAP_CYCLES   = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  poly_note_if.slave bus
);
  // state | meaning
  // IDLE  | no key held, outputs silent
  // PLAY  | owner key sounds for its slice
  // GAP   | silent pause before the next owner plays (POLY_SCHED_GAP_EN only)

  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W   = $clog2(NUM_KEYS + 1);
  localparam int SLICE_W = $clog2(SLICE_CYCLES);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);

`ifdef POLY_SCHED_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] r_gap;
`else
  typedef enum logic {S_IDLE, S_PLAY} state_t;
`endif

  // Half-period in clocks of semitone 'semi' above C3, rounded to nearest.
  function automatic logic [31:0] base_half(input int semi);
    real ratio;
    ratio = 1.0;
    for (int i = 0; i < semi; i++) ratio = ratio * 1.0594630943592953;
    return 32'($rtoi(real'(CLK_HZ) / (2.0 * 130.8128 * ratio) + 0.5));
  endfunction

  logic [31:0] w_rom [16];
  for (genvar g = 0; g < 16; g++) begin : g_rom
    localparam logic [31:0] HALF = (g < 12) ? base_half(g) : 32'd0;
    assign w_rom[g] = HALF;
  end

  state_t              r_state;
  logic [NUM_KEYS-1:0] r_keys_q, r_keys_d;
  logic [SLICE_W-1:0]  r_slice;
  logic [IDX_W-1:0]    r_owner;
  logic                r_valid;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_phase, r_half_m1;
  logic                r_pwm;

  logic             w_change, w_tc, w_phase_tc;
  logic [IDX_W-1:0] w_lowest, w_next, w_tone_idx;
  logic [CNT_W-1:0] w_pop;
  logic [3:0]       w_semi;
  logic [2:0]       w_oct;
  logic [31:0]      w_half, w_half_m1;

  always_comb begin
    w_lowest = '0;
    w_next   = '0;
    w_pop    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_keys_q[i]) w_lowest = IDX_W'(i);
    end
    w_next = w_lowest;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_keys_q[i] && (i > int'(r_owner))) w_next = IDX_W'(i);
    end
    for (int i = 0; i < NUM_KEYS; i++) w_pop = w_pop + CNT_W'(r_keys_q[i]);
  end

  assign w_change   = (r_keys_q != r_keys_d);
  assign w_tc       = (r_slice == SLICE_LAST);
  assign w_phase_tc = (r_phase >= r_half_m1);

  // Tone parameters are looked up for whichever key owns the note after this edge.
  assign w_tone_idx = w_change ? w_lowest : (w_tc ? w_next : r_owner);
  assign w_semi     = 4'(w_tone_idx % 12);
  assign w_oct      = 3'(w_tone_idx / 12) + 3'(bus.shift);
  assign w_half     = w_rom[w_semi] >> w_oct;
  assign w_half_m1  = (w_half > 32'd1) ? (w_half - 32'd1) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_keys_q  <= '0;
      r_keys_d  <= '0;
      r_slice   <= '0;
      r_owner   <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_phase   <= '0;
      r_half_m1 <= '0;
      r_pwm     <= 1'b0;
`ifdef POLY_SCHED_GAP_EN
      r_gap     <= '0;
`endif
    end else begin
      r_keys_q <= bus.keys;
      r_keys_d <= r_keys_q;
      r_count  <= w_pop;
      if (r_keys_q == '0) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_owner <= '0;
        r_slice <= '0;
        r_phase <= '0;
        r_pwm   <= 1'b0;
      end else if (w_change || (r_state == S_IDLE)) begin
        r_state   <= S_PLAY;
        r_valid   <= 1'b1;
        r_owner   <= w_lowest;
        r_slice   <= '0;
        r_phase   <= '0;
        r_pwm     <= 1'b0;
        r_half_m1 <= w_half_m1;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (w_tc) begin
              r_slice <= '0;
              r_owner <= w_next;
            end else begin
              r_slice <= r_slice + 1'b1;
            end
            // A lone key keeps its owner at the boundary, so its tone runs on uninterrupted.
            if (w_tc && (w_next != r_owner)) begin
`ifdef POLY_SCHED_GAP_EN
              r_state <= S_GAP;
              r_valid <= 1'b0;
              r_gap   <= '0;
`endif
              r_phase   <= '0;
              r_pwm     <= 1'b0;
              r_half_m1 <= w_half_m1;
            end else if (w_phase_tc) begin
              r_phase   <= '0;
              r_pwm     <= ~r_pwm;
              r_half_m1 <= w_half_m1;
            end else begin
              r_phase <= r_phase + 32'd1;
            end
          end
`ifdef POLY_SCHED_GAP_EN
          S_GAP: begin
            if (r_gap == GAP_LAST) begin
              r_state   <= S_PLAY;
              r_valid   <= 1'b1;
              r_slice   <= '0;
              r_phase   <= '0;
              r_pwm     <= 1'b0;
              r_half_m1 <= w_half_m1;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.note_idx     = r_owner;
  assign bus.note_valid   = r_valid;
  assign bus.active_count = r_count;
  assign bus.pwm          = r_pwm;
  assign bus.sd           = 1'b1;
endmodule

// File: tb/tb_poly_note_scheduler.sv
// Scoreboard bench for poly_note_scheduler: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_poly_note_scheduler;
  localparam int NK = 8;
`ifdef POLY_SCHED_GAP_EN
  localparam int G = 4;
`else
  localparam int G = 0;
`endif
  localparam int P = 16 + G;
  localparam int SEL_IDX = 0, SEL_VALID = 1, SEL_ACT = 2, SEL_PWM = 3, SEL_SD = 4;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t m_e;
  int   m_act;

  poly_note_if #(.NUM_KEYS(NK)) bus ();

  poly_note_scheduler #(
    .NUM_KEYS(NK), .CLK_HZ(1_000_000), .SLICE_CYCLES(16), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input int c, input string tag, input int sel, input int val);
    sb.push_back('{c, tag, sel, val});
  endfunction

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.sel)
        SEL_IDX:   m_act = int'(bus.note_idx);
        SEL_VALID: m_act = int'(bus.note_valid);
        SEL_ACT:   m_act = int'(bus.active_count);
        SEL_PWM:   m_act = int'(bus.pwm);
        default:   m_act = int'(bus.sd);
      endcase
      n_checks++;
      if (m_act != m_e.val) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: got %0d, expected %0d", m_e.tag, cyc, m_act, m_e.val);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b, t, r, a;
    rst_n = 1'b0;
    bus.keys = '0;
    bus.shift = 2'd0;
    chk(1, "rst_idx", SEL_IDX, 0);
    chk(1, "rst_valid", SEL_VALID, 0);
    chk(1, "rst_act", SEL_ACT, 0);
    chk(1, "rst_pwm", SEL_PWM, 0);
    chk(1, "rst_sd", SEL_SD, 1);
    step_to(2);
    rst_n = 1'b1;

    // single key: two-edge latency, H(0)=3822 at shift 0, then 1911 at shift 1
    step_to(4);
    c = cyc;
    bus.keys = 8'h01;
    t = c + 2;
    chk(c + 1, "first_lat_valid", SEL_VALID, 0);
    chk(t, "first_valid", SEL_VALID, 1);
    chk(t, "first_idx", SEL_IDX, 0);
    chk(t, "first_act", SEL_ACT, 1);
    chk(t, "first_pwm", SEL_PWM, 0);
    chk(t + 3821, "pwm_pre_t1", SEL_PWM, 0);
    chk(t + 3822, "pwm_t1", SEL_PWM, 1);
    chk(t + 7643, "pwm_pre_t2", SEL_PWM, 1);
    chk(t + 7644, "pwm_t2", SEL_PWM, 0);
    step_to(t + 7645);
    bus.shift = 2'd1;
    t = t + 11466;
    chk(t - 1, "shift_pre_t3", SEL_PWM, 0);
    chk(t, "shift_t3", SEL_PWM, 1);
    chk(t + 1910, "shift_pre_t4", SEL_PWM, 1);
    chk(t + 1911, "shift_t4", SEL_PWM, 0);
    chk(t + 3821, "shift_pre_t5", SEL_PWM, 0);
    chk(t + 3822, "shift_t5", SEL_PWM, 1);
    step_to(t + 3823);
    bus.shift = 2'd0;

    // round robin over keys 0,2,5
    c = cyc;
    bus.keys = 8'h25;
    b = c + 2;
    chk(b, "rr_idx0", SEL_IDX, 0);
    chk(b, "rr_valid", SEL_VALID, 1);
    chk(b, "rr_act", SEL_ACT, 3);
    chk(b, "rr_pwm_restart", SEL_PWM, 0);
    chk(b + 15, "rr_idx0_end", SEL_IDX, 0);
    chk(b + 16, "rr_idx2", SEL_IDX, 2);
    chk(b + 16, "rr_valid_b1", SEL_VALID, (G == 0) ? 1 : 0);
    chk(b + 16 + G, "rr_valid_p2", SEL_VALID, 1);
    chk(b + 15 + P, "rr_idx2_end", SEL_IDX, 2);
    chk(b + 16 + P, "rr_idx5", SEL_IDX, 5);
    chk(b + 15 + 2 * P, "rr_idx5_end", SEL_IDX, 5);
    chk(b + 16 + 2 * P, "rr_idx0_wrap", SEL_IDX, 0);
    chk(b + 16 + 2 * P, "rr_act_end", SEL_ACT, 3);
    step_to(b + 17 + 2 * P);

    // release the owner (key 2) mid-slice
    c = cyc;
    bus.keys = 8'h05;
    b = c + 2;
    chk(b, "rel_idx0", SEL_IDX, 0);
    chk(b + 16, "rel_idx2", SEL_IDX, 2);
    r = b + 16 + G + 5;
    step_to(r);
    bus.keys = 8'h01;
    chk(r + 1, "rel_idx_hold", SEL_IDX, 2);
    chk(r + 1, "rel_act_hold", SEL_ACT, 2);
    chk(r + 2, "rel_idx_new", SEL_IDX, 0);
    chk(r + 2, "rel_valid", SEL_VALID, 1);
    chk(r + 2, "rel_act", SEL_ACT, 1);
    chk(r + 2, "rel_pwm_low", SEL_PWM, 0);
    chk(r + 2 + 3821, "rel_pwm_pre", SEL_PWM, 0);
    chk(r + 2 + 3822, "rel_pwm_t1", SEL_PWM, 1);

    // all keys released while pwm is high
    a = r + 2 + 3832;
    step_to(a);
    bus.keys = 8'h00;
    chk(a + 1, "off_valid_hold", SEL_VALID, 1);
    chk(a + 1, "off_pwm_hold", SEL_PWM, 1);
    chk(a + 2, "off_valid", SEL_VALID, 0);
    chk(a + 2, "off_pwm", SEL_PWM, 0);
    chk(a + 2, "off_act", SEL_ACT, 0);

    // change event coinciding with slice terminal count
    step_to(a + 5);
    c = cyc;
    bus.keys = 8'h06;
    b = c + 2;
    chk(b, "bnd_idx1", SEL_IDX, 1);
    chk(b, "bnd_valid", SEL_VALID, 1);
    chk(b, "bnd_act", SEL_ACT, 2);
    step_to(b + 14);
    bus.keys = 8'h0A;
    chk(b + 15, "bnd_idx_pre", SEL_IDX, 1);
    chk(b + 16, "bnd_idx_prio", SEL_IDX, 1);
    chk(b + 16, "bnd_valid_prio", SEL_VALID, 1);
    chk(b + 16, "bnd_act_new", SEL_ACT, 2);
    chk(b + 31, "bnd_idx_slice0", SEL_IDX, 1);
    chk(b + 32, "bnd_idx3", SEL_IDX, 3);

    // asynchronous reset mid-operation, keys held
    step_to(b + 35);
    c = cyc;
    chk(c, "arst_idx", SEL_IDX, 0);
    chk(c, "arst_valid", SEL_VALID, 0);
    chk(c, "arst_act", SEL_ACT, 0);
    chk(c, "arst_pwm", SEL_PWM, 0);
    chk(c, "arst_sd", SEL_SD, 1);
    rst_n = 1'b0;
    step_to(c + 2);
    rst_n = 1'b1;
    chk(c + 3, "arst_resume_lat", SEL_VALID, 0);
    chk(c + 4, "arst_resume_valid", SEL_VALID, 1);
    chk(c + 4, "arst_resume_idx", SEL_IDX, 1);
    chk(c + 4, "arst_resume_act", SEL_ACT, 2);

    // two keys: gap (when built) between slices
    step_to(c + 6);
    c = cyc;
    bus.keys = 8'h03;
    b = c + 2;
    chk(b, "gap_idx0", SEL_IDX, 0);
    chk(b, "gap_valid0", SEL_VALID, 1);
    chk(b + 15, "gap_idx0_end", SEL_IDX, 0);
    chk(b + 16, "gap_idx1", SEL_IDX, 1);
    chk(b + 16, "gap_silent", SEL_VALID, (G == 0) ? 1 : 0);
    chk(b + 16, "gap_pwm", SEL_PWM, 0);
    chk(b + 16 + G, "gap_play_valid", SEL_VALID, 1);
    chk(b + 16 + G, "gap_play_idx", SEL_IDX, 1);
    chk(b + 15 + P, "gap_idx1_end", SEL_IDX, 1);
    chk(b + 16 + P, "gap_idx0_wrap", SEL_IDX, 0);
    step_to(b + 16 + P + 3);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_note_scheduler.md
# poly_note_scheduler

Parametrised polyphonic note scheduler and square-wave tone generator for the buzzer path. Samples an N-key vector and round-robins the pressed keys in fixed time slices, lowest key first. Drives one PWM tone for the key owning the current slice. Sits between the keyboard and record/playback logic and the buzzer amplifier pins (`pwm`, `sd`).

## Interface
- `NUM_KEYS`, 8: key vector width, 1..24. Key k maps to semitone k mod 12, octave offset k/12.
- `CLK_HZ`, 100_000_000: clock frequency in Hz, used only for the tone table.
- `SLICE_CYCLES`, 2_000_000: slice length in clocks, ≥ 2.
- `GAP_CYCLES`, 200_000: silent gap length in clocks, ≥ 1. Used only with `POLY_SCHED_GAP_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `shift` in 2: octave shift 0..3, added to the key's octave offset.
- `keys` in NUM_KEYS: pressed keys, bit k = key k.
- `note_idx` out clog2(NUM_KEYS) (min 1): key currently sounding.
- `note_valid` out 1: 1 while a note sounds.
- `active_count` out clog2(NUM_KEYS+1): number of ones in the registered key vector.
- `pwm` out 1: tone output.
- `sd` out 1: amplifier enable, constant 1.

## Operation
- `keys` is registered into `keys_q` every cycle. The scheduler uses only `keys_q` and its previous value `keys_d`.
- **Change event:** `keys_q != keys_d`. On a change event the scheduler restarts:
  - slice counter is set to 0;
  - owner is the lowest set bit of `keys_q`;
  - the tone phase restarts.
- **States:** IDLE, PLAY, and GAP (GAP exists only with the macro).
- **IDLE:**
  - `note_valid`=0 and `pwm`=0.
  - Moves to PLAY on the cycle after `keys_q` becomes nonzero.
- **PLAY:**
  - The slice counter counts 0..SLICE_CYCLES-1.
  - At terminal count, the owner advances to the next set bit above the current owner, wrapping to the lowest set bit.
  - With exactly one key pressed, the owner stays the same and the tone runs continuously; the phase is not restarted at the slice boundary.
- **All keys released:** `keys_q`=0 moves the block to IDLE from any state.
- **Owner released mid-slice:** this is a change event, so the scheduler restarts at the lowest remaining key.
- **Tone:**
  - Half-period H(k) = (round(CLK_HZ / (2·130.8128·2^((k mod 12)/12)))) >> (k/12 + shift). Base note is C3.
  - Computed at elaboration as a constant ROM.
  - The phase counter counts 0..H-1. `pwm` toggles when the counter reaches H-1, and the counter returns to 0.
  - On an owner change, `pwm`=0 and counter=0.
- **`shift` change:** takes effect at the next half-period boundary; it does not restart the phase.
- **`active_count`:** combinational popcount of `keys_q`, registered.

## Timing
- **Reset values:**
  - `note_idx`=0, `note_valid`=0, `active_count`=0, `pwm`=0, `sd`=1.
  - `keys_q`=0, `keys_d`=0; state IDLE.
- **Latency:** a `keys` value set up before edge N is in `keys_q` after edge N. `note_idx`, `note_valid` and `active_count` reflect it after edge N+1. The first `pwm` toggle occurs H cycles after edge N+1.
- **Slice boundaries:** with a constant key set, successive owner changes occur exactly SLICE_CYCLES cycles apart. With the macro, the interval is SLICE_CYCLES+GAP_CYCLES.
- **Simultaneous events:** a change event on the same edge as a slice terminal count takes priority; the owner becomes the lowest set bit.
- **Reset mid-operation:** asserting `rst_n` forces all reset values immediately, without waiting for a clock edge. Operation resumes from IDLE two cycles after deassertion, given held keys.

## Configuration
- **Macro `POLY_SCHED_GAP_EN`:**
  - **Defined:**
    - After each slice terminal count with ≥2 active keys, the block enters GAP for GAP_CYCLES with `pwm`=0 and `note_valid`=0. `note_idx` already shows the next owner.
    - It then returns to PLAY with the phase restarted.
    - A change event during GAP goes straight to PLAY at the lowest key.
  - **Undefined:** the GAP state and its counter are not built; slices run back to back.

## Test plan
Bench parameters: CLK_HZ=1_000_000, SLICE_CYCLES=16, GAP_CYCLES=4, NUM_KEYS=8.
- **Reset:** assert reset → all outputs at reset values and `sd`=1. Then `keys`=8'h01 → `note_valid`=1 and `note_idx`=0 two edges later. `pwm` toggles every 3822 cycles (shift=0); with shift=1, every 1911 cycles.
- **Round-robin:** `keys`=8'b0010_0101 → `note_idx` sequence 0,2,5,0 with each value lasting 16 cycles; `active_count`=3.
- **Release owner mid-slice:** hold 0x05; release key 2 while it owns the slice → `note_idx`=0 two edges later, `pwm` restarted low, continuous tone thereafter.
- **All released:** `keys`=0 mid-slice → `note_valid`=0 and `pwm`=0 two edges later; `active_count`=0.
- **Change at slice boundary:** change `keys` so the change event lands on the slice terminal-count edge → owner is the lowest set bit and the slice counter is 0.
- **Gap (with `POLY_SCHED_GAP_EN`):** 0x03 → 16 cycles of key 0, 4 silent cycles with `note_idx`=1, then 16 cycles of key 1. Rerun without the macro → no silent cycles.
